// File: rtl/image_loader_if.sv
// Program-memory write port driven by the serial image loader.
interface image_loader_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_data;

  modport master (output mem_we, mem_addr, mem_data);
  modport slave  (input  mem_we, mem_addr, mem_data);
endinterface

// File: rtl/image_loader.sv
// Receives a framed program image over an 8N1 serial line, writes it into
// program memory and releases the CPU once the checksum matches.
module image_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           rx,
  image_loader_if.master mem,
  output logic           cpu_run,
  output logic           error
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {FR_HDR, FR_LEN_HI, FR_LEN_LO, FR_DATA, FR_SUM, FR_RUN} fr_state_t;

  rx_state_t       r_rxState, w_rxNext;
  fr_state_t       r_frState, w_frNext;

  logic            r_rxMeta, r_rxSync, r_rxPrev;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bitIdx;
  logic [7:0]      r_shift;
  logic            r_byteValid, r_frameErr;
  logic            w_halfDone, w_bitDone;

  logic [7:0]            r_lenHi;
  logic [15:0]           r_remaining;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_sum;

  assign w_halfDone = (r_cnt == CW'(HALF - 1));
  assign w_bitDone  = (r_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    w_rxNext = r_rxState;
    unique case (r_rxState)
      RX_IDLE:  if (r_rxPrev && !r_rxSync) w_rxNext = RX_START;
      RX_START: if (w_halfDone) w_rxNext = r_rxSync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bitDone && (r_bitIdx == 3'd7)) w_rxNext = RX_STOP;
      RX_STOP:  if (w_bitDone) w_rxNext = RX_IDLE;
      default:  w_rxNext = RX_IDLE;
    endcase
  end

  // Bit counter restarts on every sample point so START (half bit) lands mid-bit
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rxMeta    <= 1'b1;
      r_rxSync    <= 1'b1;
      r_rxPrev    <= 1'b1;
      r_rxState   <= RX_IDLE;
      r_cnt       <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_byteValid <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_rxMeta    <= rx;
      r_rxSync    <= r_rxMeta;
      r_rxPrev    <= r_rxSync;
      r_rxState   <= w_rxNext;
      r_byteValid <= 1'b0;
      r_frameErr  <= 1'b0;

      if ((r_rxState == RX_IDLE) || w_bitDone || ((r_rxState == RX_START) && w_halfDone))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);

      if (r_rxState == RX_START)
        r_bitIdx <= '0;

      if ((r_rxState == RX_DATA) && w_bitDone) begin
        r_shift  <= {r_rxSync, r_shift[7:1]};
        r_bitIdx <= r_bitIdx + 3'd1;
      end

      if ((r_rxState == RX_STOP) && w_bitDone) begin
        if (r_rxSync) r_byteValid <= 1'b1;
        else          r_frameErr  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_frNext = r_frState;
    if (r_frameErr && (r_frState != FR_RUN)) begin
      w_frNext = FR_HDR;
    end else if (r_byteValid) begin
      unique case (r_frState)
        FR_HDR:    if (r_shift == 8'hA5) w_frNext = FR_LEN_HI;
        FR_LEN_HI: w_frNext = FR_LEN_LO;
        FR_LEN_LO: w_frNext = ({r_lenHi, r_shift} == 16'd0) ? FR_SUM : FR_DATA;
        FR_DATA:   if (r_remaining == 16'd1) w_frNext = FR_SUM;
        FR_SUM:    w_frNext = (r_shift == r_sum) ? FR_RUN : FR_HDR;
        FR_RUN:    w_frNext = FR_RUN;
        default:   w_frNext = FR_HDR;
      endcase
    end
  end

  // Once in RUN nothing below fires again, so cpu_run holds and mem_we stays low
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_frState    <= FR_HDR;
      r_lenHi      <= '0;
      r_remaining  <= '0;
      r_addr       <= '0;
      r_sum        <= '0;
      mem.mem_we   <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_data <= '0;
      cpu_run      <= 1'b0;
      error        <= 1'b0;
    end else begin
      r_frState  <= w_frNext;
      mem.mem_we <= 1'b0;
      if (r_frameErr && (r_frState != FR_RUN)) begin
        error <= 1'b1;
      end else if (r_byteValid) begin
        unique case (r_frState)
          FR_HDR: begin
            if (r_shift == 8'hA5) error <= 1'b0;
          end
          FR_LEN_HI: begin
            r_lenHi <= r_shift;
            r_addr  <= '0;
            r_sum   <= '0;
          end
          FR_LEN_LO: begin
            r_remaining <= {r_lenHi, r_shift};
            r_addr      <= '0;
            r_sum       <= '0;
          end
          FR_DATA: begin
            mem.mem_we   <= 1'b1;
            mem.mem_addr <= r_addr;
            mem.mem_data <= r_shift;
            r_addr       <= r_addr + ADDR_WIDTH'(1);
            r_sum        <= r_sum + r_shift;
            r_remaining  <= r_remaining - 16'd1;
          end
          FR_SUM: begin
            if (r_shift == r_sum) cpu_run <= 1'b1;
            else                  error   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: directed frame table, hand-written
// corner sequences, and randomized frames against a frame-parsing model.
module tb_image_loader;

  localparam int CLKS_PER_BIT = 16;
  localparam int ADDR_WIDTH   = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic rx      = 1'b1;
  logic cpu_run;
  logic error;

  image_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  image_loader #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .rx     (rx),
    .mem    (bus.master),
    .cpu_run(cpu_run),
    .error  (error)
  );

  always #5 clock = ~clock;

  int nChecks = 0;
  int nFails  = 0;

  logic [23:0] gotQ[$];
  logic [23:0] expQ[$];
  bit          expRun;
  bit          expErr;

  // Each sampled strobe cycle is one write; a stretched strobe shows up as an extra entry
  always @(negedge clock)
    if (reset_n && bus.mem_we) gotQ.push_back({bus.mem_addr, bus.mem_data});

  typedef struct {
    int          nBytes;
    logic [7:0]  bytes[12];
    int          badStop;
    int          nWr;
    logic [23:0] wr[4];
    bit          run;
    bit          err;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    gotQ.delete();
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit stopOk);
    rx = 1'b0;
    repeat (CLKS_PER_BIT) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLKS_PER_BIT) @(negedge clock);
    end
    rx = stopOk;
    repeat (CLKS_PER_BIT) @(negedge clock);
    if (!stopOk) begin
      rx = 1'b1;
      repeat (2 * CLKS_PER_BIT) @(negedge clock);
    end
  endtask

  task automatic compareLog(input string tag);
    logic [23:0] last;
    repeat (4) @(negedge clock);
    checkOutput({tag, " write count"}, gotQ.size(), expQ.size());
    for (int k = 0; k < expQ.size() && k < gotQ.size(); k++)
      checkOutput($sformatf("%s write %0d", tag, k), gotQ[k], expQ[k]);
    checkOutput({tag, " cpu_run"}, cpu_run, expRun);
    checkOutput({tag, " error"}, error, expErr);
    checkOutput({tag, " mem_we idle"}, bus.mem_we, 1'b0);
    last = (expQ.size() > 0) ? expQ[expQ.size()-1] : 24'h0;
    checkOutput({tag, " mem_addr hold"}, bus.mem_addr, last[23:8]);
    checkOutput({tag, " mem_data hold"}, bus.mem_data, last[7:0]);
  endtask

  // Parses the byte stream as frames: hunt for A5, take the length, write N
  // bytes from address 0, then accept or reject on the modulo-256 sum.
  task automatic refModel(input logic [7:0] s[$]);
    int         i;
    int         n;
    logic [7:0] sum;
    expQ.delete();
    expRun = 1'b0;
    expErr = 1'b0;
    i = 0;
    while (i < s.size() && !expRun) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      expErr = 1'b0;
      i++;
      if (i + 1 >= s.size()) break;
      n = int'({s[i], s[i+1]});
      i += 2;
      sum = 8'h00;
      for (int k = 0; k < n && i < s.size(); k++) begin
        expQ.push_back({16'(k), s[i]});
        sum = sum + s[i];
        i++;
      end
      if (i >= s.size()) break;
      if (s[i] == sum) expRun = 1'b1;
      else             expErr = 1'b1;
      i++;
    end
  endtask

  task automatic sendList(input logic [7:0] s[$]);
    foreach (s[k]) applyStimulus(s[k], 1'b1);
  endtask

  initial begin
    logic [7:0] stream[$];
    logic [7:0] sum;
    int         n;

    vecs[0] = '{6,  '{8'hA5,8'h00,8'h02,8'h12,8'h34,8'h46,0,0,0,0,0,0}, -1,
                2,  '{24'h000012,24'h000134,0,0}, 1'b1, 1'b0};
    vecs[1] = '{5,  '{8'hA5,8'h00,8'h01,8'h55,8'h00,0,0,0,0,0,0,0}, -1,
                1,  '{24'h000055,0,0,0}, 1'b0, 1'b1};
    vecs[2] = '{10, '{8'hA5,8'h00,8'h01,8'h55,8'h00,8'hA5,8'h00,8'h01,8'h55,8'h55,0,0}, -1,
                2,  '{24'h000055,24'h000055,0,0}, 1'b1, 1'b0};
    vecs[3] = '{5,  '{8'h3C,8'hA5,8'h00,8'h00,8'h00,0,0,0,0,0,0,0}, -1,
                0,  '{0,0,0,0}, 1'b1, 1'b0};
    vecs[4] = '{5,  '{8'hA5,8'h00,8'h02,8'h12,8'h34,0,0,0,0,0,0,0}, 4,
                1,  '{24'h000012,0,0,0}, 1'b0, 1'b1};
    vecs[5] = '{11, '{8'hA5,8'h00,8'h02,8'h12,8'h34,8'h99,8'hA5,8'h00,8'h01,8'h55,8'h55,0}, 4,
                2,  '{24'h000012,24'h000055,0,0}, 1'b1, 1'b0};
    vecs[6] = '{7,  '{8'hA5,8'h00,8'h03,8'hF0,8'h20,8'h01,8'h11,0,0,0,0,0}, -1,
                3,  '{24'h0000F0,24'h000120,24'h000201,0}, 1'b1, 1'b0};

    // Reset state, and it stays quiet while the line idles
    applyReset();
    checkOutput("reset cpu_run", cpu_run, 1'b0);
    checkOutput("reset error", error, 1'b0);
    checkOutput("reset mem_we", bus.mem_we, 1'b0);
    checkOutput("reset mem_addr", bus.mem_addr, 16'h0);
    checkOutput("reset mem_data", bus.mem_data, 8'h0);
    repeat (50) @(negedge clock);
    expQ.delete(); expRun = 1'b0; expErr = 1'b0;
    compareLog("idle");

    foreach (vecs[v]) begin
      applyReset();
      for (int j = 0; j < vecs[v].nBytes; j++)
        applyStimulus(vecs[v].bytes[j], j != vecs[v].badStop);
      expQ.delete();
      for (int k = 0; k < vecs[v].nWr; k++) expQ.push_back(vecs[v].wr[k]);
      expRun = vecs[v].run;
      expErr = vecs[v].err;
      compareLog($sformatf("vec%0d", v));
    end

    // A short low pulse is not a start bit, and the receiver still frames after it
    applyReset();
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    checkOutput("glitch error", error, 1'b0);
    checkOutput("glitch writes", gotQ.size(), 0);
    sendList('{8'hA5, 8'h00, 8'h01, 8'h77, 8'h77});
    expQ = '{24'h000077}; expRun = 1'b1; expErr = 1'b0;
    compareLog("post-glitch");

    // Sticky error clears exactly at the next header
    applyReset();
    sendList('{8'hA5, 8'h00, 8'h01, 8'h55, 8'h00});
    repeat (4) @(negedge clock);
    checkOutput("sticky error set", error, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    repeat (4) @(negedge clock);
    checkOutput("sticky error held", error, 1'b1);
    applyStimulus(8'hA5, 1'b1);
    repeat (4) @(negedge clock);
    checkOutput("error cleared by header", error, 1'b0);
    sendList('{8'h00, 8'h01, 8'h55, 8'h55});
    expQ = '{24'h000055, 24'h000055}; expRun = 1'b1; expErr = 1'b0;
    compareLog("retry");

    // Reset mid-frame discards it; after RUN further traffic is ignored
    applyReset();
    sendList('{8'hA5, 8'h00, 8'h04, 8'h11});
    repeat (4) @(negedge clock);
    checkOutput("partial frame write", gotQ.size(), 1);
    applyReset();
    sendList('{8'hA5, 8'h00, 8'h01, 8'h77, 8'h77});
    expQ = '{24'h000077}; expRun = 1'b1; expErr = 1'b0;
    compareLog("after reset");
    sendList('{8'hA5, 8'h00, 8'h01, 8'h12, 8'h12});
    applyStimulus(8'h34, 1'b0);
    compareLog("run ignores rx");

    // Randomized frames with noise, bad checksums and retries
    for (int it = 0; it < 8; it++) begin
      applyReset();
      stream.delete();
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        stream.push_back(8'($urandom_range(0, 8'hA4)));
      for (int f = 0; f < 2; f++) begin
        n = int'($urandom_range(0, 6));
        stream.push_back(8'hA5);
        stream.push_back(8'h00);
        stream.push_back(8'(n));
        sum = 8'h00;
        for (int k = 0; k < n; k++) begin
          stream.push_back(8'($urandom));
          sum = sum + stream[stream.size()-1];
        end
        if ($urandom_range(0, 1) == 1) stream.push_back(sum);
        else                           stream.push_back(sum + 8'(1 + $urandom_range(0, 254)));
      end
      refModel(stream);
      sendList(stream);
      compareLog($sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
